// File: rtl/cva6_cfg_discovery_slave.sv
// cva6_cfg_discovery_slave: read-only req/gnt/rvalid window serving the elaborated CVA6 configuration words.
package config_pkg;
  typedef enum logic [1:0] {WB = 2'd0, WT = 2'd1, HPDCACHE = 2'd2} cache_type_t;
  typedef struct packed {
    logic RVA, RVB, RVC, RVD, RVF, RVH, RVV, RVS, RVU, RVZCB, RVZCMP, RVZCMT, RVZiCond;
    logic CvxifEn, MmuPresent, DebugEn;
    int unsigned XLEN;
    int unsigned IcacheByteSize, IcacheSetAssoc, IcacheLineWidth;
    int unsigned DcacheByteSize, DcacheSetAssoc, DcacheLineWidth;
    cache_type_t DCacheType;
    int unsigned NrNonIdempotentRules, NrExecuteRegionRules, NrCachedRegionRules;
    int unsigned NrPMPEntries, NrScoreboardEntries;
    logic [63:0] HaltAddress, ExceptionAddress;
    logic [15:0][63:0] NonIdempotentAddrBase, NonIdempotentLength;
    logic [15:0][63:0] ExecuteRegionAddrBase, ExecuteRegionLength;
    logic [15:0][63:0] CachedRegionAddrBase, CachedRegionLength;
  } cva6_cfg_t;
  localparam cva6_cfg_t cva6_cfg_empty = '0;
endpackage

module cva6_cfg_discovery_slave #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter int unsigned AddrWidth = 12,
  parameter logic [63:0] Magic = 64'h4356_4136_4346_4730
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  input  logic                 rready_i,
  output logic [63:0]          rdata_o,
  output logic                 err_o,
  output logic [31:0]          rd_cnt_o
);
  typedef enum logic {Idle, Resp} state_e;
  // Rule slots beyond the configured count read as empty, so mask them at elaboration.
  function automatic logic [15:0][63:0] live(input logic [15:0][63:0] t, input int unsigned n);
    logic [15:0][63:0] r;
    r = '0;
    for (int unsigned i = 0; i < 16; i++) if (i < n) r[i] = t[i];
    return r;
  endfunction
  localparam logic [15:0][63:0] NiBase = live(CVA6Cfg.NonIdempotentAddrBase, CVA6Cfg.NrNonIdempotentRules);
  localparam logic [15:0][63:0] NiLen  = live(CVA6Cfg.NonIdempotentLength, CVA6Cfg.NrNonIdempotentRules);
  localparam logic [15:0][63:0] ExBase = live(CVA6Cfg.ExecuteRegionAddrBase, CVA6Cfg.NrExecuteRegionRules);
  localparam logic [15:0][63:0] ExLen  = live(CVA6Cfg.ExecuteRegionLength, CVA6Cfg.NrExecuteRegionRules);
  localparam logic [15:0][63:0] CaBase = live(CVA6Cfg.CachedRegionAddrBase, CVA6Cfg.NrCachedRegionRules);
  localparam logic [15:0][63:0] CaLen  = live(CVA6Cfg.CachedRegionLength, CVA6Cfg.NrCachedRegionRules);
  localparam logic [63:0] Isa = {8'(CVA6Cfg.XLEN), 40'd0, CVA6Cfg.DebugEn, CVA6Cfg.MmuPresent,
    CVA6Cfg.CvxifEn, CVA6Cfg.RVZiCond, CVA6Cfg.RVZCMT, CVA6Cfg.RVZCMP, CVA6Cfg.RVZCB, CVA6Cfg.RVU,
    CVA6Cfg.RVS, CVA6Cfg.RVV, CVA6Cfg.RVH, CVA6Cfg.RVF, CVA6Cfg.RVD, CVA6Cfg.RVC, CVA6Cfg.RVB, CVA6Cfg.RVA};
  localparam logic [63:0] Icache = {8'd0, 16'(CVA6Cfg.IcacheLineWidth), 8'(CVA6Cfg.IcacheSetAssoc),
    32'(CVA6Cfg.IcacheByteSize)};
  localparam logic [63:0] Dcache = {8'(CVA6Cfg.DCacheType), 16'(CVA6Cfg.DcacheLineWidth),
    8'(CVA6Cfg.DcacheSetAssoc), 32'(CVA6Cfg.DcacheByteSize)};
  localparam logic [63:0] Counts = {24'd0, 8'(CVA6Cfg.NrScoreboardEntries), 8'(CVA6Cfg.NrPMPEntries),
    8'(CVA6Cfg.NrCachedRegionRules), 8'(CVA6Cfg.NrExecuteRegionRules), 8'(CVA6Cfg.NrNonIdempotentRules)};
  localparam logic [7:0][63:0] Basic = {64'd0, CVA6Cfg.ExceptionAddress, CVA6Cfg.HaltAddress, Counts,
    Dcache, Icache, Isa, Magic};
  logic [AddrWidth-9:0] pg;
  logic [3:0] idx;
  logic hit, acc, err_c;
  logic [63:0] word_c, rule_c;
  state_e state_q, state_d;
  logic [63:0] rdata_q, rdata_d;
  logic err_q, err_d;
  logic [31:0] cnt_q, cnt_d;
  assign pg = addr_i[AddrWidth-1:8];
  assign idx = addr_i[7:4];
  assign hit = (pg == '0) ? (addr_i[7:3] < 5'd7) : (pg <= (AddrWidth-8)'(3));
  assign err_c = we_i | (|addr_i[2:0]) | ~hit;
  assign rule_c = (pg == (AddrWidth-8)'(1)) ? (addr_i[3] ? NiLen[idx] : NiBase[idx])
                : (pg == (AddrWidth-8)'(2)) ? (addr_i[3] ? ExLen[idx] : ExBase[idx])
                : (addr_i[3] ? CaLen[idx] : CaBase[idx]);
  assign word_c = err_c ? '0 : (pg == '0) ? Basic[addr_i[5:3]] : rule_c;
  assign gnt_o = (state_q == Idle) | rready_i;
  assign acc = req_i & gnt_o;
  always_comb begin
    state_d = acc ? Resp : (rready_i ? Idle : state_q);
    rdata_d = acc ? word_c : rdata_q;
    err_d = acc ? err_c : err_q;
    cnt_d = cnt_q + 32'(acc & ~err_c & ~&cnt_q);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      rdata_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  assign rvalid_o = state_q == Resp;
  assign rdata_o = rdata_q;
  assign err_o = err_q;
  assign rd_cnt_o = cnt_q;
endmodule

// File: tb/tb_cva6_cfg_discovery_slave.sv
// tb_cva6_cfg_discovery_slave: random traffic against a map-level reference model, plus literal spot checks.
module tb_cva6_cfg_discovery_slave;
  localparam logic [63:0] MAGIC = 64'h4356_4136_4346_4730;
  function automatic config_pkg::cva6_cfg_t ref_cfg();
    config_pkg::cva6_cfg_t c;
    c = '0;
    {c.RVA, c.RVC, c.RVD, c.RVF, c.RVS, c.RVU, c.RVZCB, c.RVZiCond} = '1;
    {c.CvxifEn, c.MmuPresent, c.DebugEn} = '1;
    c.XLEN = 64;
    c.IcacheByteSize = 16384; c.IcacheSetAssoc = 4; c.IcacheLineWidth = 128;
    c.DcacheByteSize = 32768; c.DcacheSetAssoc = 8; c.DcacheLineWidth = 128;
    c.DCacheType = config_pkg::WT;
    c.NrNonIdempotentRules = 2; c.NrExecuteRegionRules = 3; c.NrCachedRegionRules = 1;
    c.NrPMPEntries = 8; c.NrScoreboardEntries = 8;
    c.HaltAddress = 64'h800; c.ExceptionAddress = 64'h808;
    // Unused slots carry junk so an unmasked slot would show up.
    for (int i = 0; i < 16; i++) begin
      c.NonIdempotentAddrBase[i] = 64'hBAD0_0000 + 64'(i); c.NonIdempotentLength[i] = 64'hBAD1_0000 + 64'(i);
      c.ExecuteRegionAddrBase[i] = 64'hBAD2_0000 + 64'(i); c.ExecuteRegionLength[i] = 64'hBAD3_0000 + 64'(i);
      c.CachedRegionAddrBase[i] = 64'hBAD4_0000 + 64'(i);  c.CachedRegionLength[i] = 64'hBAD5_0000 + 64'(i);
    end
    c.NonIdempotentAddrBase[0] = 64'h0; c.NonIdempotentLength[0] = 64'h1000;
    c.NonIdempotentAddrBase[1] = 64'h2000_0000; c.NonIdempotentLength[1] = 64'h1000_0000;
    c.ExecuteRegionAddrBase[0] = 64'h0; c.ExecuteRegionLength[0] = 64'h1000;
    c.ExecuteRegionAddrBase[1] = 64'h1_0000; c.ExecuteRegionLength[1] = 64'h1_0000;
    c.ExecuteRegionAddrBase[2] = 64'h8000_0000; c.ExecuteRegionLength[2] = 64'h4000_0000;
    c.CachedRegionAddrBase[0] = 64'h8000_0000; c.CachedRegionLength[0] = 64'h4000_0000;
    return c;
  endfunction
  localparam config_pkg::cva6_cfg_t CFG = ref_cfg();
  logic clk, rst_n, req, we, rready, gnt, rvalid, err;
  logic [11:0] addr;
  logic [63:0] rdata, d;
  logic [31:0] rd_cnt;
  logic e;
  int vectors = 0, miscompares = 0;
  cva6_cfg_discovery_slave #(.CVA6Cfg(CFG), .AddrWidth(12), .Magic(MAGIC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .gnt_o(gnt),
    .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .err_o(err), .rd_cnt_o(rd_cnt));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic exp_err(input logic [11:0] a, input logic w);
    int unsigned o;
    o = a;
    return w || (o % 8 != 0) || !(o < 'h38 || (o >= 'h100 && o < 'h400));
  endfunction
  function automatic logic [63:0] exp_data(input logic [11:0] a, input logic w);
    int unsigned o, t, i, n;
    o = a;
    if (exp_err(a, w)) return 64'd0;
    case (o)
      'h000: return MAGIC;
      'h008: return (64'(CFG.XLEN % 256) << 56) | 64'(CFG.RVA) | (64'(CFG.RVB) << 1) | (64'(CFG.RVC) << 2)
        | (64'(CFG.RVD) << 3) | (64'(CFG.RVF) << 4) | (64'(CFG.RVH) << 5) | (64'(CFG.RVV) << 6)
        | (64'(CFG.RVS) << 7) | (64'(CFG.RVU) << 8) | (64'(CFG.RVZCB) << 9) | (64'(CFG.RVZCMP) << 10)
        | (64'(CFG.RVZCMT) << 11) | (64'(CFG.RVZiCond) << 12) | (64'(CFG.CvxifEn) << 13)
        | (64'(CFG.MmuPresent) << 14) | (64'(CFG.DebugEn) << 15);
      'h010: return 64'(CFG.IcacheByteSize) | (64'(CFG.IcacheSetAssoc % 256) << 32)
        | (64'(CFG.IcacheLineWidth % 65536) << 40);
      'h018: return 64'(CFG.DcacheByteSize) | (64'(CFG.DcacheSetAssoc % 256) << 32)
        | (64'(CFG.DcacheLineWidth % 65536) << 40) | (64'(CFG.DCacheType) << 56);
      'h020: return 64'(CFG.NrNonIdempotentRules % 256) | (64'(CFG.NrExecuteRegionRules % 256) << 8)
        | (64'(CFG.NrCachedRegionRules % 256) << 16) | (64'(CFG.NrPMPEntries % 256) << 24)
        | (64'(CFG.NrScoreboardEntries % 256) << 32);
      'h028: return CFG.HaltAddress;
      'h030: return CFG.ExceptionAddress;
      default: ;
    endcase
    t = o / 256; i = (o % 256) / 16;
    n = (t == 1) ? CFG.NrNonIdempotentRules : (t == 2) ? CFG.NrExecuteRegionRules : CFG.NrCachedRegionRules;
    if (i >= n) return 64'd0;
    if (t == 1) return (o % 16 == 8) ? CFG.NonIdempotentLength[i] : CFG.NonIdempotentAddrBase[i];
    if (t == 2) return (o % 16 == 8) ? CFG.ExecuteRegionLength[i] : CFG.ExecuteRegionAddrBase[i];
    return (o % 16 == 8) ? CFG.CachedRegionLength[i] : CFG.CachedRegionAddrBase[i];
  endfunction
  // Reference: a single response slot that is either empty or holds one answer.
  logic m_valid, m_err, m_gnt;
  logic [63:0] m_data;
  logic [31:0] m_cnt;
  assign m_gnt = !m_valid || rready;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_valid <= 1'b0; m_err <= 1'b0; m_data <= '0; m_cnt <= '0;
    end else if (req && m_gnt) begin
      m_valid <= 1'b1;
      m_err <= exp_err(addr, we);
      m_data <= exp_data(addr, we);
      m_cnt <= m_cnt + 32'(!exp_err(addr, we) && m_cnt != 32'hFFFF_FFFF);
    end else if (rready) m_valid <= 1'b0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    check("gnt", 64'(gnt), 64'(m_gnt));
    check("rvalid", 64'(rvalid), 64'(m_valid));
    check("rd_cnt", 64'(rd_cnt), 64'(m_cnt));
    if (m_valid) begin
      check("rdata", rdata, m_data);
      check("err", 64'(err), 64'(m_err));
    end
  end
  task automatic rd(input logic [11:0] a, input logic w, output logic [63:0] od, output logic oe);
    @(posedge clk); #1 req = 1'b1; addr = a; we = w; rready = 1'b1;
    @(posedge clk); #1 req = 1'b0; we = 1'b0;
    @(negedge clk); od = rdata; oe = err;
  endtask
  initial begin
    int sel;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; rready = 1'b1; addr = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_gnt", 64'(gnt), 64'd1); check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rdata", rdata, 64'd0); check("rst_cnt", 64'(rd_cnt), 64'd0);
    rd(12'h000, 1'b0, d, e); check("magic", d, 64'h4356_4136_4346_4730); check("magic_err", 64'(e), 64'd0);
    rd(12'h018, 1'b0, d, e); check("dcache", d, 64'h0100_8008_0000_8000);
    rd(12'h210, 1'b0, d, e); check("exec1_base", d, 64'h1_0000);
    rd(12'h218, 1'b0, d, e); check("exec1_len", d, 64'h1_0000);
    rd(12'h120, 1'b0, d, e); check("ni2_empty", d, 64'd0); check("ni2_err", 64'(e), 64'd0);
    rd(12'h008, 1'b1, d, e); check("wr_err", 64'(e), 64'd1); check("wr_data", d, 64'd0);
    rd(12'h009, 1'b0, d, e); check("misal_err", 64'(e), 64'd1); check("misal_data", d, 64'd0);
    rd(12'h038, 1'b0, d, e); check("unmap_err", 64'(e), 64'd1); check("unmap_data", d, 64'd0);
    check("cnt_after_errs", 64'(rd_cnt), 64'd5);
    @(posedge clk); #1 req = 1'b1; addr = 12'h028; rready = 1'b1;
    @(posedge clk); #1 rready = 1'b0; addr = 12'h030;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); check("stall_gnt", 64'(gnt), 64'd0); check("stall_rdata", rdata, 64'h800);
      @(posedge clk); #1;
    end
    rready = 1'b1;
    @(negedge clk); check("release_gnt", 64'(gnt), 64'd1);
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk); check("release_rdata", rdata, 64'h808);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      req = $urandom_range(0, 3) != 0;
      rready = $urandom_range(0, 3) != 0;
      we = $urandom_range(0, 15) == 0;
      sel = $urandom_range(0, 3);
      addr = (sel == 0) ? 12'($urandom_range(0, 7) * 8) : (sel == 1) ? 12'($urandom_range(32, 127) * 8)
           : 12'($urandom);
    end
    @(posedge clk); #1 rst_n = 1'b0; req = 1'b0; we = 1'b0; rready = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 req = 1'b1; addr = 12'h000;
    @(posedge clk); #1 addr = 12'h008;
    @(posedge clk); #1 addr = 12'h010;
    @(posedge clk); #1 addr = 12'h200;
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk); check("b2b_cnt", 64'(rd_cnt), 64'd4); check("b2b_last", rdata, 64'h0);
    @(posedge clk); #1 req = 1'b1; addr = 12'h018;
    @(posedge clk); #1 addr = 12'h020;
    @(posedge clk); #1 rst_n = 1'b0;
    #1 check("async_rvalid", 64'(rvalid), 64'd0); check("async_cnt", 64'(rd_cnt), 64'd0);
    req = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); check("no_replay", 64'(rvalid), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
